// File: rtl/dram_arbiter_if.sv
// Signal bundle between the two cores, the dram_arbiter and the shared single-port RAM.
// The master modport is the surrounding system (cores plus RAM); the slave modport is the arbiter.
interface dram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [1:0]            req;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic [1:0]            done;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  grant_id;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_q;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, ram_q,
        input  done, rdata, grant_id, busy, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, ram_q,
        output done, rdata, grant_id, busy, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter serialising two cores onto one single-port RAM.
// Each access runs IDLE -> ACCESS (RAM_LATENCY cycles) -> DONE; all outputs are registered.
module dram_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic          main_clock,
    input  logic          reset_n,
    input  logic          srst,
    dram_arbiter_if.slave bus
);
    localparam int CNT_W = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic                  last_r, last_s;
    logic                  wr_r, wr_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  grant_r, grant_s;
    logic                  busy_r, busy_s;
    logic [1:0]            done_r, done_s;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
    logic [ADDR_WIDTH-1:0] ram_addr_r, ram_addr_s;
    logic                  ram_we_r, ram_we_s;
    logic [DATA_WIDTH-1:0] ram_wdata_r, ram_wdata_s;
    logic                  winner_s;

    // A lone requester always wins; on a tie the core not served last time wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic last);
        logic w;
        case (req)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            2'b11:   w = ~last;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    assign winner_s = pick_winner(bus.req, last_r);

    // State register.
    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else if (srst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req != 2'b00) state_s = ST_ACCESS;
                else                  state_s = ST_IDLE;
            end
            ST_ACCESS: begin
                if (cnt_r == CNT_ONE) state_s = ST_DONE;
                else                  state_s = ST_ACCESS;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; ram_we and done default low so each is a single-cycle pulse.
    always_comb begin
        last_s      = last_r;
        wr_s        = wr_r;
        cnt_s       = cnt_r;
        grant_s     = grant_r;
        busy_s      = busy_r;
        done_s      = 2'b00;
        rdata_s     = rdata_r;
        ram_addr_s  = ram_addr_r;
        ram_we_s    = 1'b0;
        ram_wdata_s = ram_wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    grant_s     = winner_s;
                    last_s      = winner_s;
                    wr_s        = bus.we[winner_s];
                    cnt_s       = CNT_LOAD;
                    busy_s      = 1'b1;
                    ram_we_s    = bus.we[winner_s];
                    ram_addr_s  = winner_s ? bus.addr1  : bus.addr0;
                    ram_wdata_s = winner_s ? bus.wdata1 : bus.wdata0;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    done_s = grant_r ? 2'b10 : 2'b01;
                    if (!wr_r) rdata_s = bus.ram_q;
                    else       rdata_s = rdata_r;
                end else begin
                    done_s = 2'b00;
                end
            end
            ST_DONE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output and bookkeeping registers; LAST resets to 1 so core 0 wins the first tie.
    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            last_r      <= 1'b1;
            wr_r        <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            grant_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 2'b00;
            rdata_r     <= {DATA_WIDTH{1'b0}};
            ram_addr_r  <= {ADDR_WIDTH{1'b0}};
            ram_we_r    <= 1'b0;
            ram_wdata_r <= {DATA_WIDTH{1'b0}};
        end else if (srst) begin
            last_r      <= 1'b1;
            wr_r        <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            grant_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 2'b00;
            rdata_r     <= {DATA_WIDTH{1'b0}};
            ram_addr_r  <= {ADDR_WIDTH{1'b0}};
            ram_we_r    <= 1'b0;
            ram_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            last_r      <= last_s;
            wr_r        <= wr_s;
            cnt_r       <= cnt_s;
            grant_r     <= grant_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            rdata_r     <= rdata_s;
            ram_addr_r  <= ram_addr_s;
            ram_we_r    <= ram_we_s;
            ram_wdata_r <= ram_wdata_s;
        end
    end

    assign bus.done      = done_r;
    assign bus.rdata     = rdata_r;
    assign bus.grant_id  = grant_r;
    assign bus.busy      = busy_r;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_we    = ram_we_r;
    assign bus.ram_wdata = ram_wdata_r;
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: one instance with RAM_LATENCY=1 and one with RAM_LATENCY=3,
// each backed by a small RAM model whose read port follows the registered address.
module tb_dram_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    logic srst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic        pre_en;
    logic        pre_sel;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    always #5 clk = ~clk;

    dram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_a ();
    dram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_b ();

    dram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RAM_LATENCY(1)) dut_a (
        .main_clock(clk), .reset_n(reset_n), .srst(srst), .bus(bus_a));
    dram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RAM_LATENCY(3)) dut_b (
        .main_clock(clk), .reset_n(reset_n), .srst(srst), .bus(bus_b));

    assign bus_a.ram_q = mem_a[bus_a.ram_addr[7:0]];
    assign bus_b.ram_q = mem_b[bus_b.ram_addr[7:0]];

    // RAM A write port and preload path.
    always @(posedge clk) begin
        if (bus_a.ram_we) mem_a[bus_a.ram_addr[7:0]] <= bus_a.ram_wdata;
        else if (pre_en && !pre_sel) mem_a[pre_addr] <= pre_data;
    end

    // RAM B write port and preload path.
    always @(posedge clk) begin
        if (bus_b.ram_we) mem_b[bus_b.ram_addr[7:0]] <= bus_b.ram_wdata;
        else if (pre_en && pre_sel) mem_b[pre_addr] <= pre_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic sel, input logic [7:0] ad, input logic [15:0] d);
        pre_sel  = sel;
        pre_addr = ad;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    // Steps at least one negedge, then until a DONE bit is seen or the budget runs out.
    task automatic wait_done(input logic sel_b, input int budget, output int n);
        logic [1:0] d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            d = sel_b ? bus_b.done : bus_a.done;
        end while (d == 2'b00 && n < budget);
        n_cmp++;
        assert (d != 2'b00) else begin
            n_err++;
            $error("FAIL done_timeout: observed no DONE after %0d cycles, expected a DONE pulse", n);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        srst    = 1'b0;
        pre_en  = 1'b0; pre_sel = 1'b0; pre_addr = 8'h00; pre_data = 16'h0000;
        bus_a.req = 2'b00; bus_a.we = 2'b00; bus_a.addr0 = 16'h0000; bus_a.addr1 = 16'h0000;
        bus_a.wdata0 = 16'h0000; bus_a.wdata1 = 16'h0000;
        bus_b.req = 2'b00; bus_b.we = 2'b00; bus_b.addr0 = 16'h0000; bus_b.addr1 = 16'h0000;
        bus_b.wdata0 = 16'h0000; bus_b.wdata1 = 16'h0000;
        @(negedge clk);
        preload(1'b0, 8'h10, 16'h1234);
        preload(1'b1, 8'hFF, 16'h0A0A);

        // Reset state
        chk("reset_a", 64'({bus_a.done, bus_a.rdata, bus_a.grant_id, bus_a.busy,
                            bus_a.ram_addr, bus_a.ram_we, bus_a.ram_wdata}), 64'd0);
        chk("reset_b", 64'({bus_b.done, bus_b.rdata, bus_b.grant_id, bus_b.busy,
                            bus_b.ram_addr, bus_b.ram_we, bus_b.ram_wdata}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // T1: core 0 read of 0x0010
        bus_a.req = 2'b01; bus_a.we = 2'b00; bus_a.addr0 = 16'h0010;
        @(negedge clk);
        chk("t1_ram_we", 64'(bus_a.ram_we), 64'd0);
        chk("t1_ram_addr", 64'(bus_a.ram_addr), 64'h0010);
        chk("t1_busy", 64'(bus_a.busy), 64'd1);
        chk("t1_done_early", 64'(bus_a.done), 64'd0);
        @(negedge clk);
        chk("t1_done", 64'(bus_a.done), 64'b01);
        chk("t1_rdata", 64'(bus_a.rdata), 64'h1234);
        chk("t1_grant", 64'(bus_a.grant_id), 64'd0);
        bus_a.req = 2'b00;
        @(negedge clk);
        chk("t1_done_clear", 64'(bus_a.done), 64'd0);
        chk("t1_busy_clear", 64'(bus_a.busy), 64'd0);

        // T2: core 1 write of 0xBEEF to 0x0020, then read back by core 0
        bus_a.req = 2'b10; bus_a.we = 2'b10; bus_a.addr1 = 16'h0020; bus_a.wdata1 = 16'hBEEF;
        @(negedge clk);
        chk("t2_ram_we", 64'(bus_a.ram_we), 64'd1);
        chk("t2_ram_addr", 64'(bus_a.ram_addr), 64'h0020);
        chk("t2_ram_wdata", 64'(bus_a.ram_wdata), 64'hBEEF);
        chk("t2_grant", 64'(bus_a.grant_id), 64'd1);
        @(negedge clk);
        chk("t2_ram_we_off", 64'(bus_a.ram_we), 64'd0);
        chk("t2_done", 64'(bus_a.done), 64'b10);
        chk("t2_rdata_kept", 64'(bus_a.rdata), 64'h1234);
        bus_a.req = 2'b00; bus_a.we = 2'b00;
        @(negedge clk);
        bus_a.req = 2'b01; bus_a.addr0 = 16'h0020;
        wait_done(1'b0, 6, cyc);
        chk("t2_readback_lat", 64'(cyc), 64'd2);
        chk("t2_readback", 64'(bus_a.rdata), 64'hBEEF);
        bus_a.req = 2'b00;
        @(negedge clk);

        // T3: tie after reset alternates 0,1,0,1 with DONE every 3 cycles
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus_a.req = 2'b11; bus_a.we = 2'b00; bus_a.addr0 = 16'h0010; bus_a.addr1 = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            wait_done(1'b0, 8, cyc);
            chk($sformatf("t3_gap%0d", k), 64'(cyc), (k == 0) ? 64'd2 : 64'd3);
            chk($sformatf("t3_done%0d", k), 64'(bus_a.done), (k % 2 == 0) ? 64'b01 : 64'b10);
            chk($sformatf("t3_grant%0d", k), 64'(bus_a.grant_id), 64'(k % 2));
            chk($sformatf("t3_rdata%0d", k), 64'(bus_a.rdata), (k % 2 == 0) ? 64'h1234 : 64'hBEEF);
        end
        bus_a.req = 2'b00;
        @(negedge clk);

        // T4: core 0 re-requests back-to-back while core 1 waits
        bus_a.req = 2'b01;
        @(negedge clk);
        bus_a.req = 2'b11;
        chk("t4_grant_first", 64'(bus_a.grant_id), 64'd0);
        wait_done(1'b0, 6, cyc);
        chk("t4_done_first", 64'(bus_a.done), 64'b01);
        wait_done(1'b0, 6, cyc);
        chk("t4_done_second", 64'(bus_a.done), 64'b10);
        chk("t4_grant_second", 64'(bus_a.grant_id), 64'd1);
        bus_a.req = 2'b01;
        wait_done(1'b0, 6, cyc);
        chk("t4_done_third", 64'(bus_a.done), 64'b01);
        chk("t4_gap_third", 64'(cyc), 64'd3);
        bus_a.req = 2'b00;
        @(negedge clk);

        // T5: async reset during a core 1 write
        bus_a.req = 2'b10; bus_a.we = 2'b10; bus_a.addr1 = 16'h0030; bus_a.wdata1 = 16'h5555;
        @(negedge clk);
        chk("t5_ram_we", 64'(bus_a.ram_we), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_reset_now", 64'({bus_a.done, bus_a.rdata, bus_a.grant_id, bus_a.busy,
                                 bus_a.ram_addr, bus_a.ram_we, bus_a.ram_wdata}), 64'd0);
        @(negedge clk);
        chk("t5_no_done", 64'(bus_a.done), 64'd0);
        reset_n = 1'b1;
        bus_a.req = 2'b11; bus_a.we = 2'b00;
        wait_done(1'b0, 6, cyc);
        chk("t5_first_done", 64'(bus_a.done), 64'b01);
        chk("t5_first_grant", 64'(bus_a.grant_id), 64'd0);
        bus_a.req = 2'b00;
        @(negedge clk);

        // Synchronous soft reset abandons an access in flight
        bus_a.req = 2'b10; bus_a.addr1 = 16'h0020;
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        chk("srst_busy", 64'(bus_a.busy), 64'd0);
        chk("srst_grant", 64'(bus_a.grant_id), 64'd0);
        srst = 1'b0;
        bus_a.req = 2'b00;
        @(negedge clk);
        chk("srst_no_done", 64'(bus_a.done), 64'd0);

        // T6: RAM_LATENCY=3 read of 0x00FF with REQ dropped mid-access
        bus_b.req = 2'b01; bus_b.we = 2'b00; bus_b.addr0 = 16'h00FF;
        @(negedge clk);
        chk("t6_busy", 64'(bus_b.busy), 64'd1);
        chk("t6_ram_addr", 64'(bus_b.ram_addr), 64'h00FF);
        bus_b.req = 2'b00;
        wait_done(1'b1, 8, cyc);
        chk("t6_latency", 64'(cyc), 64'd3);
        chk("t6_done", 64'(bus_b.done), 64'b01);
        chk("t6_rdata", 64'(bus_b.rdata), 64'h0A0A);
        @(negedge clk);

        // Long-latency write keeps RAM_WE for one cycle only
        bus_b.req = 2'b10; bus_b.we = 2'b10; bus_b.addr1 = 16'h0040; bus_b.wdata1 = 16'h7777;
        @(negedge clk);
        chk("t6w_ram_we", 64'(bus_b.ram_we), 64'd1);
        chk("t6w_ram_wdata", 64'(bus_b.ram_wdata), 64'h7777);
        chk("t6w_grant", 64'(bus_b.grant_id), 64'd1);
        @(negedge clk);
        chk("t6w_ram_we_off", 64'(bus_b.ram_we), 64'd0);
        chk("t6w_addr_held", 64'(bus_b.ram_addr), 64'h0040);
        wait_done(1'b1, 8, cyc);
        chk("t6w_latency", 64'(cyc), 64'd2);
        chk("t6w_done", 64'(bus_b.done), 64'b10);
        chk("t6w_rdata_kept", 64'(bus_b.rdata), 64'h0A0A);
        bus_b.req = 2'b00;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
